// File: rtl/bist_pkg.sv
// Shared types for the LBIST sequencer.
// Holds the session FSM state encoding.
package bist_pkg;
  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
// Ports: clk, rst (sync, high), clr, inc, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
endmodule

// File: rtl/bist_sequencer.sv
// LBIST session sequencer: TPG setup/run, ORA result gathering.
// Ports: clk/rst, start handshake, TPG ctrl, ORA in, result outs.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int ERR_BITS     = 8,
  parameter int PAT_BITS     = 16,
  parameter int SETUP_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAT_BITS-1:0]      pat_count,
  input  logic                     stop_on_fail,
  input  logic                     tpg_end,
  input  logic                     cmp_valid,
  input  logic [N_CH-1:0]          ora_res,
  output logic                     tpg_reset,
  output logic                     tpg_en,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     aborted,
  output logic [N_CH-1:0]          fail_map,
  output logic [N_CH*ERR_BITS-1:0] err_count,
  output logic [PAT_BITS-1:0]      pat_cmp
);
  localparam int SW  = $clog2(SETUP_CYCLES + 1);
  localparam int PW1 = PAT_BITS + 1;

  state_t              r_state;
  state_t              w_next;
  logic [PAT_BITS-1:0] r_cnt;
  logic                r_stop;
  logic [PAT_BITS-1:0] r_issued;
  logic [SW-1:0]       r_setup;
  logic [N_CH-1:0]     r_fail;
  logic                r_aborted;
  logic                r_done;

  logic                w_accept;
  logic                w_cmp;
  logic                w_abort;
  logic [PW1-1:0]      w_iss_nx;
  logic [PW1-1:0]      w_cmp_nx;
  logic [PAT_BITS-1:0] w_pat;

  assign w_accept = start &&
    ((r_state == IDLE) || (r_state == DONE));
  assign w_cmp = cmp_valid &&
    ((r_state == RUN) || (r_state == DRAIN));
  assign w_abort = w_cmp && r_stop && (|ora_res);
  assign w_iss_nx = {1'b0, r_issued} + PW1'(1);
  // Lookahead so DONE follows the edge that registers the last compare
  assign w_cmp_nx = {1'b0, w_pat} + PW1'(w_cmp);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) w_next = SETUP;
      end
      SETUP: begin
        if (r_setup == SW'(SETUP_CYCLES - 1)) begin
          w_next = (r_cnt == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_next = DONE;
        end else if ((w_iss_nx == {1'b0, r_cnt}) || tpg_end) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_abort || (w_cmp_nx == {1'b0, r_issued})) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_stop    <= 1'b0;
      r_issued  <= '0;
      r_setup   <= '0;
      r_fail    <= '0;
      r_aborted <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == DONE) && (r_state != DONE);
      if (w_accept) begin
        r_cnt     <= pat_count;
        r_stop    <= stop_on_fail;
        r_issued  <= '0;
        r_setup   <= '0;
        r_fail    <= '0;
        r_aborted <= 1'b0;
      end else begin
        if (r_state == SETUP) r_setup <= r_setup + SW'(1);
        if (r_state == RUN) r_issued <= r_issued + PAT_BITS'(1);
        if (w_cmp) r_fail <= r_fail | ora_res;
        if (w_abort) r_aborted <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sat_counter #(.W(ERR_BITS)) u_err (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_accept),
      .inc   (w_cmp && ora_res[i]),
      .count (err_count[i*ERR_BITS +: ERR_BITS])
    );
  end

  sat_counter #(.W(PAT_BITS)) u_pat (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_accept),
    .inc   (w_cmp),
    .count (w_pat)
  );

  assign pat_cmp   = w_pat;
  assign tpg_reset = (r_state == SETUP);
  assign tpg_en    = (r_state == RUN);
  assign busy      = (r_state == SETUP) || (r_state == RUN) ||
                     (r_state == DRAIN);
  assign done      = r_done;
  assign pass      = (r_state == DONE) && (r_fail == '0);
  assign aborted   = r_aborted;
  assign fail_map  = r_fail;
endmodule
